// File: rtl/fsm_sar_mc.sv
// fsm_sar_mc: multi-channel successive-approximation ADC controller.
//
// The block scans the channels enabled in a mask. For each channel it runs one
// sample phase and then one MSB-first binary search over Width bits. It can stop
// after one pass over the mask, or keep rescanning.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous reset, active low
//   start_i      starts a scan; only looked at in IDLE
//   cont_i       1 = rescan (relatching ch_mask_i) after the last channel
//   abort_i      synchronous return to IDLE; overrides everything except reset
//   ch_mask_i    channel enable mask, latched at scan start or on relatch
//   cmp_i        comparator output, 1 = Vin >= DAC voltage
//   sample_o     track/sample switch enable
//   ch_sel_o     analog mux select (channel being converted)
//   dac_o        DAC trial code
//   result_o     last completed conversion code
//   result_ch_o  channel that result_o belongs to
//   valid_o      one-cycle pulse when result_o/result_ch_o are updated
//   eoc_o        one-cycle pulse together with valid_o for the last channel of a scan
//   busy_o       high in every state except IDLE
//
// Output semantics: there is no back-pressure. valid_o is a single-cycle
// strobe that the consumer must capture on the cycle it is high. result_o and
// result_ch_o then hold until the next strobe. eoc_o is only ever high in a
// valid_o cycle. All outputs are registered.
//
// The FSM state is held in state_q (type state_e) so it can be probed directly.
module fsm_sar_mc #(
    parameter int Width        = 6,
    parameter int Channels     = 4,
    parameter int SampleCycles = 2,
    localparam int ChW         = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                abort_i,
    input  logic [Channels-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic                sample_o,
    output logic [ChW-1:0]      ch_sel_o,
    output logic [Width-1:0]    dac_o,
    output logic [Width-1:0]    result_o,
    output logic [ChW-1:0]      result_ch_o,
    output logic                valid_o,
    output logic                eoc_o,
    output logic                busy_o
);

    localparam int KW = $clog2(Width);
    localparam int CW = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONV,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [Channels-1:0] mask_q, mask_d;
    logic [KW-1:0]       k_q, k_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [Width-1:0]    trial_q, trial_d;
    logic                sample_q, sample_d;
    logic [ChW-1:0]      ch_sel_q, ch_sel_d;
    logic [Width-1:0]    dac_q, dac_d;
    logic [Width-1:0]    result_q, result_d;
    logic [ChW-1:0]      result_ch_q, result_ch_d;
    logic                valid_q, valid_d;
    logic                eoc_q, eoc_d;
    logic                busy_q, busy_d;

    logic [Width-1:0]    kept;

    // Index of the lowest set bit of mask (0 if mask is empty).
    function automatic logic [ChW-1:0] lowest_set(input logic [Channels-1:0] mask);
        logic [ChW-1:0] idx;
        idx = '0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask[i]) idx = ChW'(i);
        end
        return idx;
    endfunction

    // True if mask has any set bit strictly above cur.
    function automatic logic has_higher(input logic [Channels-1:0] mask,
                                        input logic [ChW-1:0]      cur);
        logic found;
        found = 1'b0;
        for (int i = 0; i < Channels; i++) begin
            if (mask[i] && (i > int'(cur))) found = 1'b1;
        end
        return found;
    endfunction

    // Lowest set bit of mask strictly above cur (only meaningful if has_higher).
    function automatic logic [ChW-1:0] next_higher(input logic [Channels-1:0] mask,
                                                   input logic [ChW-1:0]      cur);
        logic [ChW-1:0] idx;
        idx = cur;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) idx = ChW'(i);
        end
        return idx;
    endfunction

    // dac_q already equals trial | bit k, so keeping the bit means taking dac_q.
    assign kept = cmp_i ? dac_q : trial_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        trial_d     = trial_q;
        sample_d    = sample_q;
        ch_sel_d    = ch_sel_q;
        dac_d       = dac_q;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        valid_d     = 1'b0;
        eoc_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sample_d = 1'b0;
                dac_d    = '0;
                if (start_i && (ch_mask_i != '0)) begin
                    mask_d   = ch_mask_i;
                    ch_sel_d = lowest_set(ch_mask_i);
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    state_d  = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (cnt_q == CW'(SampleCycles - 1)) begin
                    sample_d = 1'b0;
                    trial_d  = '0;
                    k_d      = KW'(Width - 1);
                    dac_d    = Width'(1) << (Width - 1);
                    state_d  = ST_CONV;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_CONV: begin
                trial_d = kept;
                if (k_q == '0) begin
                    dac_d       = kept;
                    result_d    = kept;
                    result_ch_d = ch_sel_q;
                    valid_d     = 1'b1;
                    eoc_d       = !has_higher(mask_q, ch_sel_q);
                    state_d     = ST_DONE;
                end else begin
                    k_d   = k_q - KW'(1);
                    dac_d = kept | (Width'(1) << (k_q - KW'(1)));
                end
            end

            ST_DONE: begin
                if (has_higher(mask_q, ch_sel_q)) begin
                    ch_sel_d = next_higher(mask_q, ch_sel_q);
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    dac_d    = '0;
                    state_d  = ST_SAMPLE;
                end else if (cont_i && (ch_mask_i != '0)) begin
                    mask_d   = ch_mask_i;
                    ch_sel_d = lowest_set(ch_mask_i);
                    cnt_d    = '0;
                    sample_d = 1'b1;
                    dac_d    = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    dac_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                sample_d = 1'b0;
                dac_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase

        // Abort discards whatever this cycle would have produced, including a
        // result that would have completed on this very edge.
        if (abort_i) begin
            state_d     = ST_IDLE;
            sample_d    = 1'b0;
            dac_d       = '0;
            valid_d     = 1'b0;
            eoc_d       = 1'b0;
            result_d    = result_q;
            result_ch_d = result_ch_q;
            mask_d      = mask_q;
            ch_sel_d    = ch_sel_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            trial_q     <= '0;
            sample_q    <= 1'b0;
            ch_sel_q    <= '0;
            dac_q       <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            eoc_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            trial_q     <= trial_d;
            sample_q    <= sample_d;
            ch_sel_q    <= ch_sel_d;
            dac_q       <= dac_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            valid_q     <= valid_d;
            eoc_q       <= eoc_d;
            busy_q      <= busy_d;
        end
    end

    assign sample_o    = sample_q;
    assign ch_sel_o    = ch_sel_q;
    assign dac_o       = dac_q;
    assign result_o    = result_q;
    assign result_ch_o = result_ch_q;
    assign valid_o     = valid_q;
    assign eoc_o       = eoc_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_fsm_sar_mc.sv
// Directed bench for fsm_sar_mc (Width=6, Channels=4, SampleCycles=2).
// The comparator is modelled as cmp_i = (vin[ch_sel_o] >= dac_o).
// Cycle numbering: cycle 1 is the interval right after the edge that samples
// start_i. Outputs are observed on the falling edge.
module tb_fsm_sar_mc;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic       cont_i;
    logic       abort_i;
    logic [3:0] ch_mask_i;
    logic       cmp_i;
    logic       sample_o;
    logic [1:0] ch_sel_o;
    logic [5:0] dac_o;
    logic [5:0] result_o;
    logic [1:0] result_ch_o;
    logic       valid_o;
    logic       eoc_o;
    logic       busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [5:0] vin [4];
    logic [5:0] exp_dac [6];
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;

    fsm_sar_mc #(
        .Width        (6),
        .Channels     (4),
        .SampleCycles (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .cont_i      (cont_i),
        .abort_i     (abort_i),
        .ch_mask_i   (ch_mask_i),
        .cmp_i       (cmp_i),
        .sample_o    (sample_o),
        .ch_sel_o    (ch_sel_o),
        .dac_o       (dac_o),
        .result_o    (result_o),
        .result_ch_o (result_ch_o),
        .valid_o     (valid_o),
        .eoc_o       (eoc_o),
        .busy_o      (busy_o)
    );

    // clock / comparator model
    always #5 clk_i = ~clk_i;
    assign cmp_i = (vin[ch_sel_o] >= dac_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // drivers
    task automatic start_scan(input logic [3:0] mask, input logic cont);
        ch_mask_i = mask;
        cont_i    = cont;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc     = 1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic expect_result(input logic [1:0] ch, input logic [5:0] val);
        exp_q.push_back({ch, val});
    endtask

    task automatic check_done(input string tag, input logic eoc, input logic [1:0] ch,
                              input logic [5:0] val);
        check({tag, "_valid"}, 32'(valid_o), 1);
        check({tag, "_eoc"}, 32'(eoc_o), 32'(eoc));
        check({tag, "_result"}, 32'(result_o), 32'(val));
        check({tag, "_result_ch"}, 32'(result_ch_o), 32'(ch));
    endtask

    // scoreboard: every valid_o pulse must match the next expected result
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(valid_o), 0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_result", 32'({result_ch_o, result_o}), 32'(sb_exp));
            end
        end
    end

    initial begin
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        cont_i    = 1'b0;
        abort_i   = 1'b0;
        ch_mask_i = 4'b0000;
        for (int i = 0; i < 4; i++) vin[i] = 6'd0;
        repeat (2) @(negedge clk_i);

        // reset state
        check("rst_sample", 32'(sample_o), 0);
        check("rst_dac", 32'(dac_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_eoc", 32'(eoc_o), 0);
        check("rst_result", 32'(result_o), 0);
        check("rst_ch_sel", 32'(ch_sel_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: single channel, binary search trace for vin0=45
        vin[0]  = 6'd45;
        exp_dac = '{6'd32, 6'd48, 6'd40, 6'd44, 6'd46, 6'd45};
        expect_result(2'd0, 6'd45);
        start_scan(4'b0001, 1'b0);
        check("t1_sample_c1", 32'(sample_o), 1);
        check("t1_busy_c1", 32'(busy_o), 1);
        check("t1_dac_c1", 32'(dac_o), 0);
        step_to(2);
        check("t1_sample_c2", 32'(sample_o), 1);
        for (int i = 0; i < 6; i++) begin
            step_to(3 + i);
            check("t1_dac", 32'(dac_o), 32'(exp_dac[i]));
        end
        check("t1_valid_c8", 32'(valid_o), 0);
        step_to(9);
        check_done("t1_c9", 1'b1, 2'd0, 6'd45);
        check("t1_dac_c9", 32'(dac_o), 45);
        step_to(10);
        check("t1_busy_c10", 32'(busy_o), 0);
        check("t1_valid_c10", 32'(valid_o), 0);
        check("t1_dac_c10", 32'(dac_o), 0);

        // 2: channels 1 and 3 at the code extremes; mask change mid-scan ignored
        vin[1] = 6'd0;
        vin[3] = 6'd63;
        expect_result(2'd1, 6'd0);
        expect_result(2'd3, 6'd63);
        start_scan(4'b1010, 1'b0);
        check("t2_ch_sel_c1", 32'(ch_sel_o), 1);
        ch_mask_i = 4'b0100;
        step_to(9);
        check_done("t2_c9", 1'b0, 2'd1, 6'd0);
        step_to(10);
        check("t2_ch_sel_c10", 32'(ch_sel_o), 3);
        check("t2_sample_c10", 32'(sample_o), 1);
        step_to(18);
        check_done("t2_c18", 1'b1, 2'd3, 6'd63);
        step_to(19);
        check("t2_busy_c19", 32'(busy_o), 0);

        // 3: continuous mode over channels 0 and 2, then drop cont_i
        vin[0] = 6'd10;
        vin[2] = 6'd20;
        repeat (2) begin
            expect_result(2'd0, 6'd10);
            expect_result(2'd2, 6'd20);
        end
        start_scan(4'b0101, 1'b1);
        step_to(9);
        check_done("t3_c9", 1'b0, 2'd0, 6'd10);
        step_to(18);
        check_done("t3_c18", 1'b1, 2'd2, 6'd20);
        step_to(19);
        check("t3_busy_c19", 32'(busy_o), 1);
        check("t3_ch_sel_c19", 32'(ch_sel_o), 0);
        step_to(27);
        check_done("t3_c27", 1'b0, 2'd0, 6'd10);
        cont_i = 1'b0;
        step_to(36);
        check_done("t3_c36", 1'b1, 2'd2, 6'd20);
        step_to(37);
        check("t3_busy_c37", 32'(busy_o), 0);

        // 4: abort in the fifth conversion cycle
        vin[0] = 6'd33;
        start_scan(4'b0001, 1'b0);
        step_to(7);
        abort_i = 1'b1;
        step_to(8);
        abort_i = 1'b0;
        check("t4_busy", 32'(busy_o), 0);
        check("t4_sample", 32'(sample_o), 0);
        check("t4_dac", 32'(dac_o), 0);
        check("t4_valid", 32'(valid_o), 0);
        check("t4_result_kept", 32'(result_o), 20);
        check("t4_result_ch_kept", 32'(result_ch_o), 2);
        step_to(12);
        check("t4_busy_c12", 32'(busy_o), 0);
        expect_result(2'd0, 6'd33);
        start_scan(4'b0001, 1'b0);
        step_to(9);
        check_done("t4_restart_c9", 1'b1, 2'd0, 6'd33);

        // 5: asynchronous reset mid-conversion, then start with empty mask
        vin[1] = 6'd50;
        start_scan(4'b0010, 1'b0);
        step_to(5);
        #2 rst_ni = 1'b0;
        #1;
        check("t5_sample", 32'(sample_o), 0);
        check("t5_dac", 32'(dac_o), 0);
        check("t5_busy", 32'(busy_o), 0);
        check("t5_result", 32'(result_o), 0);
        check("t5_ch_sel", 32'(ch_sel_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        start_scan(4'b0000, 1'b0);
        check("t5_busy_c1", 32'(busy_o), 0);
        step_to(4);
        check("t5_busy_c4", 32'(busy_o), 0);
        check("t5_sample_c4", 32'(sample_o), 0);

        // 6: start_i held high is only re-accepted once back in IDLE
        vin[0] = 6'd7;
        expect_result(2'd0, 6'd7);
        expect_result(2'd0, 6'd7);
        ch_mask_i = 4'b0001;
        cont_i    = 1'b0;
        start_i   = 1'b1;
        @(negedge clk_i);
        cyc = 1;
        step_to(3);
        check("t6_dac_c3", 32'(dac_o), 32);
        step_to(9);
        check_done("t6_c9", 1'b1, 2'd0, 6'd7);
        step_to(10);
        check("t6_busy_c10", 32'(busy_o), 0);
        step_to(11);
        check("t6_busy_c11", 32'(busy_o), 1);
        start_i = 1'b0;
        step_to(19);
        check_done("t6_c19", 1'b1, 2'd0, 6'd7);
        step_to(22);
        check("t6_busy_c22", 32'(busy_o), 0);

        repeat (3) @(negedge clk_i);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
